// File: rtl/spi_controller.sv
// SPI mode-0 host: frames {rw, addr[6:0], data[7:0]} MSB-first on COPI under nCS, SCLK idles low.
// One command per valid/ready handshake; cmd_ready only in IDLE; all outputs registered off clk.
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS
);

  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          sclk_q, sclk_d;
  logic          copi_q, copi_d;
  logic          ncs_q, ncs_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    ncs_d   = ncs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d = SETUP;
          shreg_d = {cmd_write, cmd_addr, cmd_data};
          copi_d  = cmd_write;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end else begin
          ready_d = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = 4'd15;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // Bit 0's falling edge ends the frame; COPI keeps bit 0 through HOLD.
            if (bit_q == 4'd0) begin
              state_d = HOLD;
            end else begin
              bit_d   = bit_q - 4'd1;
              shreg_d = {shreg_q[14:0], 1'b0};
              copi_d  = shreg_q[14];
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign SCLK      = sclk_q;
  assign COPI      = copi_q;
  assign nCS       = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: default-parameter instance checked by line monitors,
// plus a slow instance looped back into a 2-FF-synchronised register-file peripheral model.
module tb_spi_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       a_rst, a_valid, a_ready, a_write, a_busy, a_done, a_sclk, a_copi, a_ncs;
  logic [6:0] a_addr;
  logic [7:0] a_data;

  spi_controller dut_a (
    .clk(clk), .rst(a_rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_write(a_write), .cmd_addr(a_addr), .cmd_data(a_data),
    .busy(a_busy), .done(a_done), .SCLK(a_sclk), .COPI(a_copi), .nCS(a_ncs)
  );

  // Instance B: slow SCLK, minimal chip-select margins
  logic       b_rst, b_valid, b_ready, b_write, b_busy, b_done, b_sclk, b_copi, b_ncs;
  logic [6:0] b_addr;
  logic [7:0] b_data;

  spi_controller #(.CLK_DIV(8), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(4)) dut_b (
    .clk(clk), .rst(b_rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_write(b_write), .cmd_addr(b_addr), .cmd_data(b_data),
    .busy(b_busy), .done(b_done), .SCLK(b_sclk), .COPI(b_copi), .nCS(b_ncs)
  );

  int errors = 0;
  int checks = 0;

  // Line monitor A: rising-edge capture, nCS low/high lengths, done pulses, framing rules
  int          a_rises = 0, a_dones = 0, a_viol = 0;
  int          a_low_cnt = 0, a_high_cnt = 0, a_low_len = 0, a_gap = 0;
  logic [15:0] a_frame = 16'h0000;
  logic        a_psclk = 1'b0, a_pncs = 1'b1;

  always @(negedge clk) begin
    if (a_rst !== 1'b1) begin
      if ((a_sclk !== a_psclk) && (a_ncs === 1'b1 || a_pncs === 1'b1)) a_viol++;
      if ((a_ncs !== a_pncs) && (a_sclk === 1'b1 || a_psclk === 1'b1)) a_viol++;
    end
    if (a_sclk === 1'b1 && a_psclk === 1'b0) begin
      a_rises++;
      a_frame = {a_frame[14:0], a_copi};
    end
    if (a_ncs === 1'b0) a_low_cnt++;
    else if (a_pncs === 1'b0 && a_ncs === 1'b1) begin a_low_len = a_low_cnt; a_low_cnt = 0; end
    if (a_ncs === 1'b1) a_high_cnt++;
    else if (a_pncs === 1'b1 && a_ncs === 1'b0) begin a_gap = a_high_cnt; a_high_cnt = 0; end
    if (a_done === 1'b1) a_dones++;
    a_psclk = a_sclk;
    a_pncs  = a_ncs;
  end

  // Line monitor B
  int          b_rises = 0, b_viol = 0, b_low_cnt = 0, b_low_len = 0;
  logic [15:0] b_frame = 16'h0000;
  logic        b_psclk = 1'b0, b_pncs = 1'b1;

  always @(negedge clk) begin
    if (b_rst !== 1'b1) begin
      if ((b_sclk !== b_psclk) && (b_ncs === 1'b1 || b_pncs === 1'b1)) b_viol++;
      if ((b_ncs !== b_pncs) && (b_sclk === 1'b1 || b_psclk === 1'b1)) b_viol++;
    end
    if (b_sclk === 1'b1 && b_psclk === 1'b0) begin
      b_rises++;
      b_frame = {b_frame[14:0], b_copi};
    end
    if (b_ncs === 1'b0) b_low_cnt++;
    else if (b_pncs === 1'b0 && b_ncs === 1'b1) begin b_low_len = b_low_cnt; b_low_cnt = 0; end
    b_psclk = b_sclk;
    b_pncs  = b_ncs;
  end

  // Peripheral model for B: {nCS,SCLK,COPI} through two flops, shift on synced SCLK rise
  logic [2:0]  p_s1, p_s2;
  logic        p_psclk, p_pncs;
  logic [15:0] p_sh;
  logic [4:0]  p_nb;
  logic [7:0]  p_regs [128];

  always @(negedge clk) begin
    if (b_rst === 1'b1) begin
      p_s1    <= 3'b100;
      p_s2    <= 3'b100;
      p_psclk <= 1'b0;
      p_pncs  <= 1'b1;
      p_sh    <= 16'h0000;
      p_nb    <= 5'd0;
      for (int i = 0; i < 128; i++) p_regs[i] <= 8'h00;
    end else begin
      p_s1    <= {b_ncs, b_sclk, b_copi};
      p_s2    <= p_s1;
      p_psclk <= p_s2[1];
      p_pncs  <= p_s2[2];
      if (!p_s2[2] && p_s2[1] && !p_psclk) begin
        p_sh <= {p_sh[14:0], p_s2[0]};
        p_nb <= p_nb + 5'd1;
      end
      if (p_s2[2] && !p_pncs) begin
        if (p_nb == 5'd16 && p_sh[15]) p_regs[p_sh[14:8]] <= p_sh[7:0];
        p_nb <= 5'd0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready_a(input string nm);
    int n = 0;
    while (a_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk({nm, " cmd_ready"}, a_ready, 1);
  endtask

  task automatic send_a(input logic w, input logic [6:0] ad, input logic [7:0] d, input string nm);
    wait_ready_a(nm);
    a_valid = 1'b1; a_write = w; a_addr = ad; a_data = d;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic wait_done_a(input string nm);
    int n = 0;
    while (a_done !== 1'b1 && n < 2000) begin tick(); n++; end
    chk({nm, " done seen"}, a_done, 1);
  endtask

  // One complete frame on A with framing, timing and handshake checks
  task automatic run_a(input logic w, input logic [6:0] ad, input logic [7:0] d,
                       input logic [15:0] ef, input int elow, input string nm);
    int r0, d0;
    r0 = a_rises;
    d0 = a_dones;
    send_a(w, ad, d, nm);
    chk({nm, " nCS low after accept"}, a_ncs, 0);
    chk({nm, " busy after accept"}, a_busy, 1);
    chk({nm, " COPI bit15 in setup"}, a_copi, ef[15]);
    chk({nm, " cmd_ready dropped"}, a_ready, 0);
    wait_done_a(nm);
    chk({nm, " nCS high at done"}, a_ncs, 1);
    repeat (3) tick();
    chk({nm, " busy through gap"}, a_busy, 1);
    tick();
    chk({nm, " busy low 4 after done"}, a_busy, 0);
    chk({nm, " cmd_ready back"}, a_ready, 1);
    chk({nm, " frame"}, a_frame, ef);
    chk({nm, " sclk rises"}, a_rises - r0, 16);
    chk({nm, " nCS low cycles"}, a_low_len, elow);
    chk({nm, " done pulses"}, a_dones - d0, 1);
  endtask

  typedef struct {
    logic        w;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] frame;
    int          low_len;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, n;

    vecs[0] = '{1'b1, 7'h00, 8'hF0, 16'h80F0, 132};
    vecs[1] = '{1'b0, 7'h04, 8'h5A, 16'h045A, 132};
    vecs[2] = '{1'b1, 7'h7F, 8'hFF, 16'hFFFF, 132};
    vecs[3] = '{1'b0, 7'h00, 8'h00, 16'h0000, 132};
    vecs[4] = '{1'b1, 7'h55, 8'hA5, 16'hD5A5, 132};

    a_rst = 1'b1; a_valid = 1'b0; a_write = 1'b0; a_addr = 7'h00; a_data = 8'h00;
    b_rst = 1'b1; b_valid = 1'b0; b_write = 1'b0; b_addr = 7'h00; b_data = 8'h00;
    repeat (3) tick();

    chk("reset nCS", a_ncs, 1);
    chk("reset SCLK", a_sclk, 0);
    chk("reset COPI", a_copi, 0);
    chk("reset done", a_done, 0);
    chk("reset busy", a_busy, 0);
    chk("reset cmd_ready", a_ready, 0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();
    chk("cmd_ready after reset", a_ready, 1);

    for (int i = 0; i < 5; i++)
      run_a(vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].frame, vecs[i].low_len,
            $sformatf("vec%0d", i));

    // Back-to-back with cmd_valid held high
    r0 = a_rises;
    d0 = a_dones;
    wait_ready_a("b2b");
    a_valid = 1'b1; a_write = 1'b1; a_addr = 7'h01; a_data = 8'h3C;
    tick();
    a_addr = 7'h02; a_data = 8'hC3;
    wait_done_a("b2b first");
    chk("b2b first frame", a_frame, 16'h813C);
    n = 0;
    while (a_ncs !== 1'b0 && n < 50) begin tick(); n++; end
    chk("b2b second start", a_ncs, 0);
    a_valid = 1'b0;
    tick();
    chk("b2b nCS high gap", a_gap, 5);
    wait_done_a("b2b second");
    chk("b2b second frame", a_frame, 16'h82C3);
    repeat (8) tick();
    chk("b2b done pulses", a_dones - d0, 2);
    chk("b2b sclk rises", a_rises - r0, 32);
    chk("b2b idle busy", a_busy, 0);

    // Reset in the middle of a frame
    r0 = a_rises;
    d0 = a_dones;
    send_a(1'b1, 7'h11, 8'h22, "midrst");
    n = 0;
    while (a_rises - r0 < 5 && n < 200) begin tick(); n++; end
    chk("midrst SCLK high at 5th rise", a_sclk, 1);
    a_rst = 1'b1;
    tick();
    chk("midrst nCS", a_ncs, 1);
    chk("midrst SCLK", a_sclk, 0);
    chk("midrst COPI", a_copi, 0);
    chk("midrst done", a_done, 0);
    chk("midrst cmd_ready in reset", a_ready, 0);
    a_rst = 1'b0;
    tick();
    chk("midrst cmd_ready after release", a_ready, 1);
    repeat (20) tick();
    chk("midrst no done", a_dones - d0, 0);
    chk("midrst no rises after reset", a_rises - r0, 5);
    run_a(1'b1, 7'h12, 8'h34, 16'h9234, 132, "after midrst");

    // cmd_valid pulsed during SHIFT is ignored
    r0 = a_rises;
    d0 = a_dones;
    send_a(1'b0, 7'h33, 8'h66, "ignore");
    n = 0;
    while (a_rises - r0 < 3 && n < 200) begin tick(); n++; end
    a_valid = 1'b1; a_write = 1'b1; a_addr = 7'h7F; a_data = 8'hFF;
    tick();
    chk("ignore cmd_ready in shift", a_ready, 0);
    tick();
    a_valid = 1'b0;
    wait_done_a("ignore");
    chk("ignore frame", a_frame, 16'h3366);
    repeat (30) tick();
    chk("ignore single done", a_dones - d0, 1);
    chk("ignore no second frame", a_rises - r0, 16);
    chk("ignore idle nCS", a_ncs, 1);

    // Slow instance into synchronised peripheral model
    n = 0;
    while (b_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("loop cmd_ready", b_ready, 1);
    b_valid = 1'b1; b_write = 1'b1; b_addr = 7'h02; b_data = 8'hAA;
    tick();
    b_valid = 1'b0;
    n = 0;
    while (b_done !== 1'b1 && n < 2000) begin tick(); n++; end
    chk("loop done seen", b_done, 1);
    repeat (8) tick();
    chk("loop reg[2]", p_regs[2], 8'hAA);
    chk("loop reg[3] untouched", p_regs[3], 8'h00);
    chk("loop frame", b_frame, 16'h82AA);
    chk("loop sclk rises", b_rises, 16);
    chk("loop nCS low cycles", b_low_len, 258);

    chk("A framing rule violations", a_viol, 0);
    chk("B framing rule violations", b_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
